ahb_slave_mem: RTL and testbench

Synthesizable AHB slave backed by a byte-addressable on-chip memory; the responder end of the AHB master tester traffic. One instance per slave port of the interconnect. Each instance occupies one `P_SIZE_IN_BYTES` window selected by `HSEL`. It supports:
- single and burst transfers;
- optional wait-state insertion;
- the two-cycle ERROR response for illegal accesses.

---
 rtl/ahb_pkg.sv | 41 ++++
 rtl/ahb_slave_mem_if.sv | 24 ++
 rtl/ahb_slv_mem_array.sv | 27 ++
 rtl/ahb_slave_mem.sv | 142 ++++++++++++++
 tb/tb_ahb_slave_mem.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB encodings, slave FSM state type and transfer-decode helpers.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_ERR1 = 2'b10,
    ST_ERR2 = 2'b11
  } state_t;

  // A transfer is legal when its size is at most a word and the address is naturally aligned.
  function automatic logic size_legal(input logic [2:0] size, input logic [1:0] a);
    case (size)
      HSIZE_BYTE: return 1'b1;
      HSIZE_HALF: return ~a[0];
      HSIZE_WORD: return (a == 2'b00);
      default:    return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] a);
    case (size)
      HSIZE_BYTE: return 4'b0001 << a;
      HSIZE_HALF: return a[1] ? 4'b1100 : 4'b0011;
      default:    return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/ahb_slave_mem_if.sv
// AHB slave-side bus bundle: decoder select, address/control, write data and the slave response.
interface ahb_slave_mem_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic [1:0]  HRESP;
  logic [31:0] HRDATA;

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADY,
    output HREADYOUT, HRESP, HRDATA
  );

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA,
    input  HREADY, HREADYOUT, HRESP, HRDATA
  );
endinterface

// File: rtl/ahb_slv_mem_array.sv
// Byte-lane RAM: one 8-bit array per lane, synchronous masked write, asynchronous read, no reset.
module ahb_slv_mem_array #(
  parameter int P_WORDS = 256,
  parameter int WW      = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [WW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [WW-1:0] raddr,
  output logic [31:0]   rdata
);

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [P_WORDS];

      always_ff @(posedge clk) begin
        if (we && be[gi]) lane_mem[waddr] <= wdata[8*gi +: 8];
      end

      assign rdata[8*gi +: 8] = lane_mem[raddr];
    end
  endgenerate

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB slave with byte-addressable memory, two-cycle ERROR response and, when AHB_SLV_WAIT_EN
// is defined, P_WAIT_CYCLES wait states per legal data phase.
module ahb_slave_mem
  import ahb_pkg::*;
#(
  parameter int P_SIZE_IN_BYTES = 1024,
  parameter int P_WAIT_CYCLES   = 2
) (
  input logic           HCLK,
  input logic           HRESET,
  ahb_slave_mem_if.slave bus
);

  localparam int AW = $clog2(P_SIZE_IN_BYTES);
  localparam int WW = AW - 2;

  state_t        state_reg;
  logic [AW-1:0] dp_addr_reg;
  logic          dp_write_reg;
  logic [2:0]    dp_size_reg;
  logic          dp_valid_reg;
  logic          hready_out_reg;
  logic [1:0]    hresp_reg;
  logic [31:0]   hrdata_reg;
`ifdef AHB_SLV_WAIT_EN
  logic [3:0]    wait_cnt_reg;
`endif

  logic          accept;
  logic          legal;
  logic          commit;
  logic [3:0]    wr_be;
  logic [WW-1:0] rd_waddr;
  logic [31:0]   mem_rdata;
  logic [31:0]   fwd_rdata;
  logic          unused_bits;

  assign accept = (state_reg == ST_IDLE || state_reg == ST_ERR2)
                  && bus.HSEL && bus.HREADY && bus.HTRANS[1];
  assign legal  = size_legal(bus.HSIZE, bus.HADDR[1:0]);
  // A write lands on the last data-phase cycle, which is always spent in ST_IDLE.
  assign commit = (state_reg == ST_IDLE) && dp_valid_reg && dp_write_reg;
  assign wr_be  = lane_mask(dp_size_reg, dp_addr_reg[1:0]);
  assign rd_waddr = (state_reg == ST_WAIT) ? dp_addr_reg[AW-1:2] : bus.HADDR[AW-1:2];

  assign unused_bits = ^{bus.HBURST, bus.HADDR[31:AW], bus.HTRANS[0]};

  ahb_slv_mem_array #(
    .P_WORDS (P_SIZE_IN_BYTES / 4),
    .WW      (WW)
  ) u_mem (
    .clk   (HCLK),
    .we    (commit),
    .be    (wr_be),
    .waddr (dp_addr_reg[AW-1:2]),
    .wdata (bus.HWDATA),
    .raddr (rd_waddr),
    .rdata (mem_rdata)
  );

  // A read accepted while a write to the same word commits must see the new bytes.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_fwd
      assign fwd_rdata[8*gi +: 8] =
          (commit && wr_be[gi] && (dp_addr_reg[AW-1:2] == rd_waddr))
          ? bus.HWDATA[8*gi +: 8] : mem_rdata[8*gi +: 8];
    end
  endgenerate

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_reg      <= ST_IDLE;
      dp_addr_reg    <= '0;
      dp_write_reg   <= 1'b0;
      dp_size_reg    <= HSIZE_BYTE;
      dp_valid_reg   <= 1'b0;
      hready_out_reg <= 1'b1;
      hresp_reg      <= HRESP_OKAY;
      hrdata_reg     <= '0;
`ifdef AHB_SLV_WAIT_EN
      wait_cnt_reg   <= '0;
`endif
    end else begin
      case (state_reg)
        ST_IDLE, ST_ERR2: begin
          dp_valid_reg <= accept && legal;
          if (accept) begin
            dp_addr_reg  <= bus.HADDR[AW-1:0];
            dp_write_reg <= bus.HWRITE;
            dp_size_reg  <= bus.HSIZE;
          end
          if (accept && !legal) begin
            state_reg      <= ST_ERR1;
            hready_out_reg <= 1'b0;
            hresp_reg      <= HRESP_ERROR;
          end
`ifdef AHB_SLV_WAIT_EN
          else if (accept && P_WAIT_CYCLES > 0) begin
            state_reg      <= ST_WAIT;
            hready_out_reg <= 1'b0;
            hresp_reg      <= HRESP_OKAY;
            wait_cnt_reg   <= 4'(P_WAIT_CYCLES - 1);
          end
`endif
          else begin
            state_reg      <= ST_IDLE;
            hready_out_reg <= 1'b1;
            hresp_reg      <= HRESP_OKAY;
            if (accept && !bus.HWRITE) hrdata_reg <= fwd_rdata;
          end
        end
`ifdef AHB_SLV_WAIT_EN
        ST_WAIT: begin
          if (wait_cnt_reg == 4'd0) begin
            state_reg      <= ST_IDLE;
            hready_out_reg <= 1'b1;
            if (!dp_write_reg) hrdata_reg <= fwd_rdata;
          end else begin
            wait_cnt_reg <= wait_cnt_reg - 4'd1;
          end
        end
`endif
        ST_ERR1: begin
          state_reg      <= ST_ERR2;
          hready_out_reg <= 1'b1;
          hresp_reg      <= HRESP_ERROR;
        end
        default: begin
          state_reg      <= ST_IDLE;
          hready_out_reg <= 1'b1;
          hresp_reg      <= HRESP_OKAY;
          dp_valid_reg   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.HREADYOUT = hready_out_reg;
  assign bus.HRESP     = hresp_reg;
  assign bus.HRDATA    = hrdata_reg;

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Directed bench for ahb_slave_mem: a small pipelined AHB master engine plus hand-computed expectations.
module tb_ahb_slave_mem;
  import ahb_pkg::*;

`ifdef AHB_SLV_WAIT_EN
  localparam int EXP_WAITS = 2;
`else
  localparam int EXP_WAITS = 0;
`endif

  typedef struct {
    logic [1:0]  trans;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } beat_t;

  logic HCLK = 1'b0;
  logic HRESET = 1'b1;
  int   n_total = 0;
  int   n_bad = 0;

  beat_t       seq [16];
  int          n_beats = 0;
  logic [31:0] res_rdata [16];
  logic [1:0]  res_resp  [16];
  logic [1:0]  res_first [16];
  int          res_waits [16];

  ahb_slave_mem_if bus ();
  assign bus.HREADY = bus.HREADYOUT;

  ahb_slave_mem #(
    .P_SIZE_IN_BYTES (1024),
    .P_WAIT_CYCLES   (2)
  ) dut (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .bus    (bus)
  );

  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic add(input logic [1:0] trans, input logic wr, input logic [2:0] size,
                     input logic [31:0] addr, input logic [31:0] wdata);
    seq[n_beats] = '{trans, wr, size, addr, wdata};
    n_beats++;
  endtask

  task automatic drive_addr(input int i);
    if (i < n_beats) begin
      bus.HTRANS = seq[i].trans;
      bus.HWRITE = seq[i].wr;
      bus.HSIZE  = seq[i].size;
      bus.HADDR  = seq[i].addr;
    end else begin
      bus.HTRANS = HTRANS_IDLE;
      bus.HWRITE = 1'b0;
    end
  endtask

  // Runs the queued beats as a pipelined master; entered and left at posedge+1.
  task automatic run_seq();
    int ai = 0;
    int di = -1;
    int guard = 0;
    bit ready;
    bit first = 0;
    for (int i = 0; i < 16; i++) begin
      res_waits[i] = 0;
      res_rdata[i] = '0;
      res_resp[i]  = 2'b11;
      res_first[i] = 2'b11;
    end
    drive_addr(0);
    while (ai < n_beats || di >= 0) begin
      @(negedge HCLK);
      ready = bus.HREADYOUT;
      if (di >= 0) begin
        if (first) begin
          res_first[di] = bus.HRESP;
          first = 0;
        end
        if (ready) begin
          res_rdata[di] = bus.HRDATA;
          res_resp[di]  = bus.HRESP;
        end else begin
          res_waits[di]++;
        end
      end
      @(posedge HCLK);
      #1;
      if (ready) begin
        if (ai < n_beats) begin
          di = seq[ai].trans[1] ? ai : -1;
          bus.HWDATA = seq[ai].wdata;
          ai++;
        end else begin
          di = -1;
        end
        first = (di >= 0);
        drive_addr(ai);
      end
      guard++;
      if (guard > 200) begin
        n_total++;
        n_bad++;
        $display("FAIL seq_timeout: got %0d cycles required at most 200", guard);
        drive_addr(n_beats);
        break;
      end
    end
    n_beats = 0;
  endtask

  initial begin
    bus.HSEL = 1'b1; bus.HADDR = '0; bus.HTRANS = HTRANS_IDLE; bus.HWRITE = 1'b0;
    bus.HSIZE = HSIZE_WORD; bus.HBURST = 3'b000; bus.HWDATA = '0;
    repeat (2) @(posedge HCLK);
    #1;
    chk("rst_hreadyout", 32'(bus.HREADYOUT), 32'd1);
    chk("rst_hresp", 32'(bus.HRESP), 32'd0);
    chk("rst_hrdata", bus.HRDATA, 32'h0);
    @(negedge HRESET ? HCLK : HCLK);
    HRESET = 1'b0;
    @(posedge HCLK);
    #1;

    // Word write then read of the same address, back to back.
    add(HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h10, 32'hDEAD_BEEF);
    add(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h10, 32'h0);
    run_seq();
    chk("wr_word_resp", 32'(res_resp[0]), 32'(HRESP_OKAY));
    chk("wr_word_waits", 32'(res_waits[0]), 32'(EXP_WAITS));
    chk("rd_word_data", res_rdata[1], 32'hDEAD_BEEF);
    chk("rd_word_resp", 32'(res_resp[1]), 32'(HRESP_OKAY));
    chk("rd_word_waits", 32'(res_waits[1]), 32'(EXP_WAITS));

    // Byte lanes; unused lanes carry junk that must be masked off.
    add(HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h20, 32'h1122_3344);
    add(HTRANS_NONSEQ, 1'b1, HSIZE_BYTE, 32'h22, 32'hFFAA_FFFF);
    add(HTRANS_NONSEQ, 1'b1, HSIZE_HALF, 32'h20, 32'hEEEE_BBCC);
    add(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h20, 32'h0);
    add(HTRANS_NONSEQ, 1'b1, HSIZE_BYTE, 32'h27, 32'h77EE_EEEE);
    add(HTRANS_NONSEQ, 1'b1, HSIZE_HALF, 32'h26, 32'h0000_0000);
    add(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h24, 32'h0);
    run_seq();
    chk("lanes_rd_20", res_rdata[3], 32'h11AA_BBCC);
    chk("lanes_rd_resp", 32'(res_resp[3]), 32'(HRESP_OKAY));
    chk("lanes_half_resp", 32'(res_resp[2]), 32'(HRESP_OKAY));

    // Error responses; the read presented during ERR1/ERR2 must complete OKAY.
    add(HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h00, 32'hCAFE_F00D);
    add(HTRANS_NONSEQ, 1'b1, HSIZE_HALF, 32'h01, 32'h1234_5678);
    add(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h00, 32'h0);
    add(HTRANS_NONSEQ, 1'b1, 3'b011,     32'h00, 32'h5555_5555);
    add(HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h02, 32'h6666_6666);
    add(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h00, 32'h0);
    run_seq();
    chk("err_half_first", 32'(res_first[1]), 32'(HRESP_ERROR));
    chk("err_half_last", 32'(res_resp[1]), 32'(HRESP_ERROR));
    chk("err_half_low_cycles", 32'(res_waits[1]), 32'd1);
    chk("err_next_rd_data", res_rdata[2], 32'hCAFE_F00D);
    chk("err_next_rd_resp", 32'(res_resp[2]), 32'(HRESP_OKAY));
    chk("err_size_last", 32'(res_resp[3]), 32'(HRESP_ERROR));
    chk("err_size_low_cycles", 32'(res_waits[3]), 32'd1);
    chk("err_misalign_first", 32'(res_first[4]), 32'(HRESP_ERROR));
    chk("err_mem_unchanged", res_rdata[5], 32'hCAFE_F00D);

    // Burst writes with a BUSY beat, then burst reads.
    add(HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h110, 32'h0F0F_0F0F);
    add(HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h100, 32'd1);
    add(HTRANS_SEQ,    1'b1, HSIZE_WORD, 32'h104, 32'd2);
    add(HTRANS_BUSY,   1'b1, HSIZE_WORD, 32'h110, 32'hBAD0_BAD0);
    add(HTRANS_SEQ,    1'b1, HSIZE_WORD, 32'h108, 32'd3);
    add(HTRANS_SEQ,    1'b1, HSIZE_WORD, 32'h10C, 32'd4);
    add(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h100, 32'h0);
    add(HTRANS_SEQ,    1'b0, HSIZE_WORD, 32'h104, 32'h0);
    add(HTRANS_SEQ,    1'b0, HSIZE_WORD, 32'h108, 32'h0);
    add(HTRANS_SEQ,    1'b0, HSIZE_WORD, 32'h10C, 32'h0);
    add(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h110, 32'h0);
    run_seq();
    chk("burst_rd0", res_rdata[6], 32'd1);
    chk("burst_rd1", res_rdata[7], 32'd2);
    chk("burst_rd2", res_rdata[8], 32'd3);
    chk("burst_rd3", res_rdata[9], 32'd4);
    chk("burst_rd3_waits", 32'(res_waits[9]), 32'(EXP_WAITS));
    chk("busy_no_write", res_rdata[10], 32'h0F0F_0F0F);

    // Reset in the middle of a write data phase.
    add(HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h40, 32'h1234_5678);
    run_seq();
    bus.HTRANS = HTRANS_NONSEQ; bus.HWRITE = 1'b1; bus.HSIZE = HSIZE_WORD; bus.HADDR = 32'h40;
    @(posedge HCLK);
    #1;
    bus.HTRANS = HTRANS_IDLE; bus.HWRITE = 1'b0; bus.HWDATA = 32'h5555_5555;
    @(negedge HCLK);
`ifdef AHB_SLV_WAIT_EN
    chk("rstmid_in_wait", 32'(bus.HREADYOUT), 32'd0);
`endif
    HRESET = 1'b1;
    #1;
    chk("rstmid_hreadyout", 32'(bus.HREADYOUT), 32'd1);
    chk("rstmid_hresp", 32'(bus.HRESP), 32'd0);
    chk("rstmid_hrdata", bus.HRDATA, 32'h0);
    @(posedge HCLK);
    @(negedge HCLK);
    HRESET = 1'b0;
    @(posedge HCLK);
    #1;
    add(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h40, 32'h0);
    run_seq();
    chk("rstmid_no_commit", res_rdata[0], 32'h1234_5678);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
